// File: rtl/param_bitwise_or.sv
// param_bitwise_or: registered, width-parameterized bitwise OR of two
// operands. The OR result travels through a PIPE_STAGES-deep shift
// pipeline of {valid, data} registers. The pipeline never stalls.
//
// Parameters
//   WIDTH        operand/result width in bits (>= 1)
//   PIPE_STAGES  number of output register stages (1..4)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; clears every stage
//   i0, i1     operands; narrow values are zero-extended by the driver
//   in_valid   operands valid this cycle
//   result     final-stage i0 | i1
//   out_valid  result belongs to an accepted operand pair
//   any_set    |result, decoded from the final-stage register
//   all_set    &result, held low until the first valid output after reset
module param_bitwise_or #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned PIPE_STAGES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic             in_valid,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic             any_set,
    output logic             all_set
);

    localparam int unsigned LAST = PIPE_STAGES - 1;

    // Bits are independent: no carry between positions.
    logic [WIDTH-1:0] or_c;
    assign or_c = i0 | i1;

    logic [WIDTH-1:0]       data_q  [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] valid_q;

    // Stage 0 captures data every cycle; valid qualifies it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q[0]  <= '0;
            valid_q[0] <= 1'b0;
        end else begin
            data_q[0]  <= or_c;
            valid_q[0] <= in_valid;
        end
    end

    // Remaining stages shift unconditionally, so there are no bubbles.
    for (genvar s = 1; s < PIPE_STAGES; s++) begin : g_stage
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q[s]  <= '0;
                valid_q[s] <= 1'b0;
            end else begin
                data_q[s]  <= data_q[s-1];
                valid_q[s] <= valid_q[s-1];
            end
        end
    end

    // Sticky flag: a valid result has left the pipeline since reset.
    logic seen_valid_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_valid_q <= 1'b0;
        end else if (valid_q[LAST]) begin
            seen_valid_q <= 1'b1;
        end
    end

    assign result    = data_q[LAST];
    assign out_valid = valid_q[LAST];
    assign any_set   = |data_q[LAST];
    // Gate all_set so a tracked-but-invalid all-ones value after reset
    // does not look like a real saturated result.
    assign all_set   = (seen_valid_q | valid_q[LAST]) & (&data_q[LAST]);

endmodule

// File: tb/tb_param_bitwise_or.sv
// Testbench for param_bitwise_or: four instances (16b/1 stage, 16b/3
// stages, 1b/4 stages, 33b/2 stages) share clock, reset and in_valid.
// Expected results are queued when operands are issued and popped by a
// monitor whenever a DUT presents out_valid; each entry carries the
// cycle on which it must appear.
module tb_param_bitwise_or;

    typedef struct {
        logic [32:0] data;
        logic        any;
        logic        all;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] a16, b16;
    logic [0:0]  a1, b1;
    logic [32:0] a33, b33;

    logic [15:0] r_p1, r_p3;
    logic [0:0]  r_w1;
    logic [32:0] r_w33;
    logic        ov_p1, ov_p3, ov_w1, ov_w33;
    logic        an_p1, an_p3, an_w1, an_w33;
    logic        al_p1, al_p3, al_w1, al_w33;

    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    exp_t sb [4][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    param_bitwise_or #(.WIDTH(16), .PIPE_STAGES(1)) u_p1 (
        .clk(clk), .rst_n(rst_n), .i0(a16), .i1(b16), .in_valid(in_valid),
        .result(r_p1), .out_valid(ov_p1), .any_set(an_p1), .all_set(al_p1));

    param_bitwise_or #(.WIDTH(16), .PIPE_STAGES(3)) u_p3 (
        .clk(clk), .rst_n(rst_n), .i0(a16), .i1(b16), .in_valid(in_valid),
        .result(r_p3), .out_valid(ov_p3), .any_set(an_p3), .all_set(al_p3));

    param_bitwise_or #(.WIDTH(1), .PIPE_STAGES(4)) u_w1 (
        .clk(clk), .rst_n(rst_n), .i0(a1), .i1(b1), .in_valid(in_valid),
        .result(r_w1), .out_valid(ov_w1), .any_set(an_w1), .all_set(al_w1));

    param_bitwise_or #(.WIDTH(33), .PIPE_STAGES(2)) u_w33 (
        .clk(clk), .rst_n(rst_n), .i0(a33), .i1(b33), .in_valid(in_valid),
        .result(r_w33), .out_valid(ov_w33), .any_set(an_w33), .all_set(al_w33));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic push(input int k, input logic [32:0] d, input int w, input int p);
        exp_t        e;
        logic [32:0] mask;
        mask   = (33'(1) << w) - 33'(1);
        e.data = d;
        e.any  = (d != 33'(0));
        e.all  = (d == mask);
        e.due  = cyc + p;
        sb[k].push_back(e);
    endtask

    // Issue one operand pair; e16 is the hand-computed 16-bit OR.
    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic v,
                         input logic [15:0] e16);
        @(negedge clk);
        a16      = a;
        b16      = b;
        in_valid = v;
        a1       = 1'($urandom);
        b1       = 1'($urandom);
        a33      = 33'({$urandom, $urandom});
        b33      = 33'({$urandom, $urandom});
        if (v) begin
            push(0, 33'(e16), 16, 1);
            push(1, 33'(e16), 16, 3);
            push(2, 33'(a1 | b1), 1, 4);
            push(3, a33 | b33, 33, 2);
        end
    endtask

    task automatic mon(input int k, input string nm, input logic [32:0] res,
                       input logic ov, input logic an, input logic al);
        exp_t e;
        if (ov) begin
            if (sb[k].size() == 0) begin
                n_total++;
                $display("FAIL %s_valid: got out_valid=1, expected 0 (cycle %0d)", nm, cyc);
            end else begin
                e = sb[k].pop_front();
                chk({nm, "_cycle"}, 64'(cyc), 64'(e.due));
                chk({nm, "_result"}, 64'(res), 64'(e.data));
                chk({nm, "_any_set"}, 64'(an), 64'(e.any));
                chk({nm, "_all_set"}, 64'(al), 64'(e.all));
            end
        end else if (sb[k].size() != 0 && sb[k][0].due <= cyc) begin
            n_total++;
            $display("FAIL %s_valid: got out_valid=0, expected 1 (cycle %0d)", nm, cyc);
            void'(sb[k].pop_front());
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            mon(0, "p1", 33'(r_p1), ov_p1, an_p1, al_p1);
            mon(1, "p3", 33'(r_p3), ov_p3, an_p3, al_p3);
            mon(2, "w1", 33'(r_w1), ov_w1, an_w1, al_w1);
            mon(3, "w33", r_w33, ov_w33, an_w33, al_w33);
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_p1_result"}, 64'(r_p1), 64'(0));
        chk({tag, "_p1_out_valid"}, 64'(ov_p1), 64'(0));
        chk({tag, "_p1_any_set"}, 64'(an_p1), 64'(0));
        chk({tag, "_p1_all_set"}, 64'(al_p1), 64'(0));
        chk({tag, "_p3_result"}, 64'(r_p3), 64'(0));
        chk({tag, "_p3_out_valid"}, 64'(ov_p3), 64'(0));
        chk({tag, "_w33_out_valid"}, 64'(ov_w33), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a16 = '0; b16 = '0; a1 = '0; b1 = '0; a33 = '0; b33 = '0;
        #12;
        chk_reset("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Invalid all-ones before any valid output: result tracks, all_set held low.
        drive(16'hFFFF, 16'h0000, 1'b0, 16'h0000);
        @(posedge clk);
        #1;
        chk("pre_valid_result", 64'(r_p1), 64'h0000_FFFF);
        chk("pre_valid_out_valid", 64'(ov_p1), 64'(0));
        chk("pre_valid_any_set", 64'(an_p1), 64'(1));
        chk("pre_valid_all_set", 64'(al_p1), 64'(0));

        // Directed vectors, back to back.
        drive(16'hCCC0, 16'h1111, 1'b1, 16'hDDD1);
        drive(16'hEEE0, 16'h2222, 1'b1, 16'hEEE2);
        drive(16'hEEE0, 16'h1111, 1'b1, 16'hFFF1);
        drive(16'h0003, 16'h0005, 1'b1, 16'h0007);
        drive(16'h0009, 16'h0001, 1'b1, 16'h0009);
        drive(16'h0001, 16'h0001, 1'b1, 16'h0001);
        drive(16'h000F, 16'h0000, 1'b1, 16'h000F);
        drive(16'h0000, 16'h000F, 1'b1, 16'h000F);
        drive(16'hFFFF, 16'h0000, 1'b1, 16'hFFFF);
        drive(16'h0000, 16'h0000, 1'b1, 16'h0000);

        // Pipeline depth stream.
        drive(16'h0001, 16'h0000, 1'b1, 16'h0001);
        drive(16'h0002, 16'h0000, 1'b1, 16'h0002);
        drive(16'h0004, 16'h0000, 1'b1, 16'h0004);

        // Valid gap 1,0,1.
        drive(16'h00A0, 16'h000A, 1'b1, 16'h00AA);
        drive(16'h1234, 16'h0000, 1'b0, 16'h0000);
        drive(16'h0F00, 16'h00F0, 1'b1, 16'h0FF0);

        // Mid-stream asynchronous reset between clock edges.
        drive(16'h8000, 16'h0001, 1'b1, 16'h8001);
        drive(16'h4000, 16'h0002, 1'b1, 16'h4002);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("midrst");
        for (int k = 0; k < 4; k++) sb[k].delete();
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(16'h5000, 16'h0A00, 1'b1, 16'h5A00);
        drive(16'h0000, 16'h0000, 1'b0, 16'h0000);

        // Random sweep against the reference OR; occasional invalid cycles.
        for (int n = 0; n < 24; n++) begin
            logic [15:0] ra, rb;
            logic        rv;
            ra = 16'($urandom);
            rb = 16'($urandom);
            rv = ($urandom_range(0, 3) != 0);
            drive(ra, rb, rv, ra | rb);
        end

        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        chk("drain_p1", 64'(sb[0].size()), 64'(0));
        chk("drain_p3", 64'(sb[1].size()), 64'(0));
        chk("drain_w1", 64'(sb[2].size()), 64'(0));
        chk("drain_w33", 64'(sb[3].size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/param_bitwise_or.md
# param_bitwise_or

Registered, width-parameterized bitwise OR of two equal-width operand vectors, with a valid flag and reduction status bits. It is a datapath leaf inside the CPU logic unit, next to the AND/XOR/NOT blocks, and is selected for OR-class instructions. The output is pipelined by a configurable number of register stages so it can be retimed without changing the interface.

## Interface
Parameters:
- WIDTH, default 16: operand and result width in bits; legal range ≥ 1.
- PIPE_STAGES, default 1: number of output register stages; legal range 1..4.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- i0  input  WIDTH  operand 0.
- i1  input  WIDTH  operand 1.
- in_valid  input  1  operands valid this cycle.
- result  output  WIDTH  registered i0 | i1.
- out_valid  output  1  result corresponds to an accepted operand pair.
- any_set  output  1  reduction OR of result.
- all_set  output  1  reduction AND of result.

## Operation
- Bit i of the result is i0[i] | i1[i], for every i in 0..WIDTH-1. There is no carry or interaction between bits.
- Operands narrower than WIDTH are zero-extended by the driver. The block performs no sign handling.
- The combinational OR feeds a shift pipeline of PIPE_STAGES registers. Each stage holds {valid, data}.
- Stage 0 loads {in_valid, i0|i1} every cycle.
- When in_valid=0, stage 0 still captures the data, but its valid bit is 0. result then tracks the inputs, and consumers must qualify it with out_valid.
- The pipeline never stalls; there is no ready or back-pressure input.
- any_set and all_set are computed combinationally from the final-stage result register. They are therefore aligned with result and out_valid.
- There is no state machine.

## Timing
- Latency is PIPE_STAGES rising edges from input to result/out_valid. With the default of 1, operands sampled at edge N appear on result just after edge N.
- Throughput is one operand pair per cycle.
- Reset, while rst_n=0 and with no clock required:
  - all stage registers are cleared;
  - result = 0, out_valid = 0, any_set = 0;
  - all_set = 0 (forced during reset and until the first valid output; otherwise all_set = &result).
- If reset is asserted mid-stream, all in-flight operands are discarded. Nothing is replayed after rst_n deasserts.
- rst_n deassertion is synchronized externally; the block needs no internal synchronizer.
- Back-to-back changing inputs each produce their own result, in order, with no bubbles.

## Test plan
- Directed vectors at WIDTH=16, PIPE_STAGES=1, in_valid=1:
  - 0xCCC0 | 0x1111 -> result 0xDDD1, any_set=1, all_set=0.
  - 0xEEE0 | 0x2222 -> 0xEEE2.
  - 0xEEE0 | 0x1111 -> 0xFFF1.
- Zero-extended narrow values:
  - 0x0003 | 0x0005 -> 0x0007.
  - 0x0009 | 0x0001 -> 0x0009.
  - 0x0001 | 0x0001 -> 0x0001.
- Complementary and extreme cases:
  - 0x000F | 0x0000 -> 0x000F.
  - 0x0000 | 0x000F -> 0x000F.
  - 0xFFFF | 0x0000 -> all_set=1.
  - 0x0000 | 0x0000 -> any_set=0.
- Reset behaviour:
  - Assert rst_n=0 asynchronously mid-stream -> result=0 and out_valid=0 immediately, with no clock edge.
  - After release, the first valid output arrives PIPE_STAGES cycles after the first accepted input.
- Pipeline depth: at PIPE_STAGES=3, stream 0x0001, 0x0002, 0x0004 (OR 0x0000) -> the same values appear in order, 3 cycles later, on consecutive cycles.
- Valid gaps and width sweep:
  - in_valid toggling 1,0,1 -> out_valid shows the pattern 1,0,1 delayed by PIPE_STAGES.
  - Repeat the random compare against the reference OR at WIDTH=1 and WIDTH=33.
